// File: rtl/vx_launch_ctrl.sv
// Kernel-launch sequencer: holds the core in reset, replays a DCR table, then times busy.
// Optional run watchdog is enabled by defining VX_LAUNCH_TIMEOUT_EN.
module vx_launch_ctrl #(
`ifdef VX_LAUNCH_TIMEOUT_EN
  parameter int unsigned RUN_TIMEOUT = 32'd16777216,
`endif
  parameter int unsigned NUM_DCRS       = 8,
  parameter int unsigned DCR_ADDR_WIDTH = 12,
  parameter int unsigned DCR_DATA_WIDTH = 32,
  parameter int unsigned RESET_CYCLES   = 16,
  parameter int unsigned BUSY_WAIT      = 1024,
  parameter int unsigned CYCLE_W        = 48,
  localparam int unsigned IW = $clog2(NUM_DCRS),
  localparam int unsigned CW = IW + 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cfg_wr_valid,
  input  logic [IW-1:0]             cfg_wr_idx,
  input  logic [DCR_ADDR_WIDTH-1:0] cfg_wr_addr,
  input  logic [DCR_DATA_WIDTH-1:0] cfg_wr_data,
  input  logic [CW-1:0]             cfg_count,
  input  logic                      start,
  output logic                      idle,
  output logic                      vx_reset,
  output logic                      dcr_wr_valid,
  output logic [DCR_ADDR_WIDTH-1:0] dcr_wr_addr,
  output logic [DCR_DATA_WIDTH-1:0] dcr_wr_data,
  input  logic                      busy,
  output logic                      done,
  output logic                      error,
`ifdef VX_LAUNCH_TIMEOUT_EN
  output logic                      timeout,
`endif
  output logic [CYCLE_W-1:0]        cycles
);

  localparam int unsigned TMAX =
    (RESET_CYCLES > BUSY_WAIT) ? RESET_CYCLES : BUSY_WAIT;
  localparam int unsigned TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] RST_LAST  = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(BUSY_WAIT - 1);
`ifdef VX_LAUNCH_TIMEOUT_EN
  localparam logic [CYCLE_W-1:0] TMO_LAST = CYCLE_W'(RUN_TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_HOLD,
    S_DCR_WR,
    S_WAIT_BUSY,
    S_RUN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [DCR_ADDR_WIDTH-1:0] tbl_addr [NUM_DCRS];
  logic [DCR_DATA_WIDTH-1:0] tbl_data [NUM_DCRS];

  logic [TW-1:0]             tmr_q, tmr_d;
  logic [CW-1:0]             idx_q, idx_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      err_q, err_d;
  logic [CYCLE_W-1:0]        cyc_q, cyc_d;
  logic                      vld_q, vld_d;
  logic [DCR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DCR_DATA_WIDTH-1:0] data_q, data_d;
  logic                      idle_q;
  logic                      vxr_q;
  logic                      done_q;
`ifdef VX_LAUNCH_TIMEOUT_EN
  logic                      tmo_q, tmo_d;
`endif

  always_ff @(posedge clk) begin
    if (cfg_wr_valid) begin
      tbl_addr[cfg_wr_idx] <= cfg_wr_addr;
      tbl_data[cfg_wr_idx] <= cfg_wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    cyc_d   = cyc_q;
    vld_d   = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef VX_LAUNCH_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = cfg_count;
          err_d   = 1'b0;
          cyc_d   = '0;
          tmr_d   = '0;
`ifdef VX_LAUNCH_TIMEOUT_EN
          tmo_d   = 1'b0;
`endif
          state_d = S_RST_HOLD;
        end
      end
      S_RST_HOLD: begin
        if (tmr_q == RST_LAST) begin
          tmr_d = '0;
          // First strobe is issued here so it lands right after the hold.
          if (cnt_q != '0) begin
            vld_d   = 1'b1;
            addr_d  = tbl_addr[0];
            data_d  = tbl_data[0];
            idx_d   = CW'(1);
            state_d = S_DCR_WR;
          end else begin
            state_d = S_WAIT_BUSY;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_DCR_WR: begin
        if (idx_q == cnt_q) begin
          state_d = S_WAIT_BUSY;
        end else begin
          vld_d  = 1'b1;
          addr_d = tbl_addr[idx_q[IW-1:0]];
          data_d = tbl_data[idx_q[IW-1:0]];
          idx_d  = idx_q + CW'(1);
        end
      end
      S_WAIT_BUSY: begin
        if (busy) begin
          cyc_d   = CYCLE_W'(1);
          state_d = S_RUN;
        end else if (tmr_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_RUN: begin
        if (!busy) begin
          state_d = S_DONE;
        end else begin
          if (cyc_q != '1) cyc_d = cyc_q + CYCLE_W'(1);
`ifdef VX_LAUNCH_TIMEOUT_EN
          if (cyc_q >= TMO_LAST) begin
            tmo_d   = 1'b1;
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      cyc_q   <= '0;
      vld_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      idle_q  <= 1'b1;
      vxr_q   <= 1'b1;
      done_q  <= 1'b0;
`ifdef VX_LAUNCH_TIMEOUT_EN
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      idle_q  <= (state_d == S_IDLE);
      vxr_q   <= !((state_d == S_WAIT_BUSY) ||
                   (state_d == S_RUN));
      done_q  <= (state_d == S_DONE);
`ifdef VX_LAUNCH_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign idle         = idle_q;
  assign vx_reset     = vxr_q;
  assign dcr_wr_valid = vld_q;
  assign dcr_wr_addr  = addr_q;
  assign dcr_wr_data  = data_q;
  assign done         = done_q;
  assign error        = err_q;
  assign cycles       = cyc_q;
`ifdef VX_LAUNCH_TIMEOUT_EN
  assign timeout      = tmo_q;
`endif

endmodule

// File: tb/tb_vx_launch_ctrl.sv
// Randomized bench for vx_launch_ctrl against a cycle-timeline reference model.
// Define VX_LAUNCH_TIMEOUT_EN to also exercise the run watchdog (RUN_TIMEOUT=64).
module tb_vx_launch_ctrl;

  localparam int ND  = 8;
  localparam int RC  = 16;
  localparam int BW  = 1024;
  localparam int TMO = 64;

  logic        clk;
  logic        reset_n;
  logic        cfg_wr_valid;
  logic [2:0]  cfg_wr_idx;
  logic [11:0] cfg_wr_addr;
  logic [31:0] cfg_wr_data;
  logic [3:0]  cfg_count;
  logic        start;
  logic        idle;
  logic        vx_reset;
  logic        dcr_wr_valid;
  logic [11:0] dcr_wr_addr;
  logic [31:0] dcr_wr_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [47:0] cycles;
`ifdef VX_LAUNCH_TIMEOUT_EN
  logic        timeout;
`endif

  int n_chk;
  int n_fail;

  logic [11:0] m_addr [ND];
  logic [31:0] m_data [ND];

  vx_launch_ctrl #(
`ifdef VX_LAUNCH_TIMEOUT_EN
    .RUN_TIMEOUT(TMO),
`endif
    .NUM_DCRS(ND),
    .DCR_ADDR_WIDTH(12),
    .DCR_DATA_WIDTH(32),
    .RESET_CYCLES(RC),
    .BUSY_WAIT(BW),
    .CYCLE_W(48)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cfg_wr_valid(cfg_wr_valid),
    .cfg_wr_idx(cfg_wr_idx),
    .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data),
    .cfg_count(cfg_count),
    .start(start),
    .idle(idle),
    .vx_reset(vx_reset),
    .dcr_wr_valid(dcr_wr_valid),
    .dcr_wr_addr(dcr_wr_addr),
    .dcr_wr_data(dcr_wr_data),
    .busy(busy),
    .done(done),
    .error(error),
`ifdef VX_LAUNCH_TIMEOUT_EN
    .timeout(timeout),
`endif
    .cycles(cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input int idx,
                           input logic [11:0] a,
                           input logic [31:0] d);
    cfg_wr_valid = 1'b1;
    cfg_wr_idx   = 3'(idx);
    cfg_wr_addr  = a;
    cfg_wr_data  = d;
    m_addr[idx]  = a;
    m_data[idx]  = d;
    @(posedge clk);
    #1;
    cfg_wr_valid = 1'b0;
  endtask

  // Cycle 0 is the start cycle; l == 0 means busy never rises.
  // wcyc < 0 means no table write during the run.
  task automatic run_launch(input int cnt, input int d, input int l,
                            input int wcyc, input int widx,
                            input logic [11:0] wa,
                            input logic [31:0] wd,
                            input bit xst);
    logic [11:0] ea [ND];
    logic [31:0] ed [ND];
    int r, xend, iend, dn, last;
    bit nb, tmo;
    for (int i = 0; i < ND; i++) begin
      ea[i] = m_addr[i];
      ed[i] = m_data[i];
    end
    // A write is seen only if it lands before that entry is fetched.
    if (wcyc >= 0 && wcyc < RC + widx) begin
      ea[widx] = wa;
      ed[widx] = wd;
    end
    r   = RC + 1 + cnt;
    nb  = (l == 0);
    tmo = 1'b0;
`ifdef VX_LAUNCH_TIMEOUT_EN
    tmo = !nb && (l >= TMO);
`endif
    dn = -1;
    if (nb) begin
      xend = r + BW;
      iend = xend;
    end else if (tmo) begin
      xend = r + d + TMO;
      iend = xend;
    end else begin
      xend = r + d + l + 1;
      iend = xend + 1;
      dn   = xend;
    end
    last = iend + 1;
    if (!nb && r + d + l > last) last = r + d + l;
    cfg_count = 4'(cnt);
    for (int k = 0; k <= last; k++) begin
      start = (k == 0) || (xst && !nb && k == r + d + 1);
      busy  = !nb && k >= r + d && k < r + d + l;
      cfg_wr_valid = (k == wcyc);
      if (k == wcyc) begin
        cfg_wr_idx  = 3'(widx);
        cfg_wr_addr = wa;
        cfg_wr_data = wd;
      end
      @(negedge clk);
      if (k == 0) begin
        chk("idle_at_start", idle, 1);
      end else begin
        chk("idle", idle, k >= iend);
        chk("vx_reset", vx_reset, !(k >= r && k < xend));
        chk("dcr_valid", dcr_wr_valid, k >= RC + 1 && k < r);
        if (k >= RC + 1 && k < r) begin
          chk("dcr_addr", dcr_wr_addr, ea[k-RC-1]);
          chk("dcr_data", dcr_wr_data, ed[k-RC-1]);
        end
        chk("done", done, k == dn);
        chk("error", error, (nb || tmo) && k >= xend);
`ifdef VX_LAUNCH_TIMEOUT_EN
        chk("timeout", timeout, tmo && k >= xend);
`endif
        if (k == 1) chk("cycles_clr", cycles, 0);
        if (dn >= 0 && k == iend) chk("cycles", cycles, l);
      end
      @(posedge clk);
      #1;
    end
    start        = 1'b0;
    busy         = 1'b0;
    cfg_wr_valid = 1'b0;
    if (wcyc >= 0) begin
      m_addr[widx] = wa;
      m_data[widx] = wd;
    end
  endtask

  initial begin
    int cnt, d, l, wc, wi;
    n_chk        = 0;
    n_fail       = 0;
    reset_n      = 1'b0;
    cfg_wr_valid = 1'b0;
    cfg_wr_idx   = '0;
    cfg_wr_addr  = '0;
    cfg_wr_data  = '0;
    cfg_count    = '0;
    start        = 1'b0;
    busy         = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_idle", idle, 1);
    chk("rst_vx_reset", vx_reset, 1);
    chk("rst_valid", dcr_wr_valid, 0);
    chk("rst_addr", dcr_wr_addr, 0);
    chk("rst_data", dcr_wr_data, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_cycles", cycles, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    cfg_write(0, 12'h001, 32'h8000_0000);
    cfg_write(1, 12'h002, 32'h0000_0000);
    cfg_write(2, 12'h003, 32'h0000_0001);
    for (int i = 3; i < ND; i++)
      cfg_write(i, 12'($urandom), $urandom);

    run_launch(3, 5, 100, -1, 0, '0, '0, 1'b0);
    run_launch(0, 0, 1, -1, 0, '0, '0, 1'b0);
    run_launch(2, 0, 0, -1, 0, '0, '0, 1'b0);
    run_launch(4, 3, 20, RC + 3, 1, 12'h0AA, 32'hCAFE_F00D, 1'b1);
    run_launch(4, 2, 5, -1, 0, '0, '0, 1'b0);
    run_launch(2, 1, 3, 0, 0, 12'h155, 32'h1234_5678, 1'b0);
    run_launch(1, 2, 200, -1, 0, '0, '0, 1'b0);

    cfg_count = 4'd4;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (RC) @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_valid0", dcr_wr_valid, 1);
    chk("mid_addr0", dcr_wr_addr, m_addr[0]);
    @(posedge clk);
    #1;
    chk("mid_valid1", dcr_wr_valid, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", dcr_wr_valid, 0);
    chk("arst_vx_reset", vx_reset, 1);
    chk("arst_idle", idle, 1);
    chk("arst_done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_launch(4, 1, 7, -1, 0, '0, '0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < ND; i++)
        if ($urandom_range(0, 1) == 1)
          cfg_write(i, 12'($urandom), $urandom);
      cnt = $urandom_range(0, ND);
      d   = $urandom_range(0, 30);
      l   = $urandom_range(1, 120);
      wc  = -1;
      wi  = $urandom_range(0, ND - 1);
      if ($urandom_range(0, 1) == 1) begin
        wc = $urandom_range(0, RC + cnt + 2);
        if (wc == RC + wi) wc++;
      end
      run_launch(cnt, d, l, wc, wi, 12'($urandom), $urandom,
                 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
